// File: rtl/mem_boot_sequencer.sv
// mem_boot_sequencer
// Boot/run/dump controller for the pipelined RISC-V cpu. It streams a program
// image into instruction and data memory while the core is disabled, enables
// the core for a programmed number of cycles, then streams a data-memory region
// back out with backpressure.
//
// Ports
//   clk, arst_n                  clock, asynchronous active-low reset
//   start, abort                 sequence request / synchronous abort
//   imem_count, dmem_count       words to load (clamped to memory depth)
//   run_cycles                   cycles with cpu_enable high
//   dump_count                   data words to read back from address 0
//   s_valid/s_ready/s_data       load stream (instruction beats use [31:0])
//   m_valid/m_ready/m_data       dump stream
//   cpu_enable                   cpu enable
//   addr_ext..wdata_ext          instruction-memory external port
//   addr_ext_2..wdata_ext_2      data-memory external port, rdata_ext_2 read data
//   busy, done                   status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, all outputs quiet
// LOAD_I   | accepting instruction beats, one imem write per beat
// LOAD_D   | accepting data beats, one dmem write per beat
// RUN      | first cycle drains last write, then cpu_enable for run_cycles
// DUMP_RD  | issue dmem read for word k (waits one cycle after LOAD_D)
// DUMP_CAP | capture read data into m_data
// DUMP_OUT | present m_data until m_ready
// DONE     | sequence finished, done held high
module mem_boot_sequencer #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] imem_count,
  input  logic [CNT_W-1:0] dmem_count,
  input  logic [31:0]      run_cycles,
  input  logic [CNT_W-1:0] dump_count,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE
  } state_t;

  state_t state_q, state_nxt;
  state_t start_first, after_i, after_d, after_run;

  logic [CNT_W-1:0] imem_q, dmem_q, dump_q, word_cnt;
  logic [CNT_W-1:0] imem_clamp, dmem_clamp, dump_clamp, idx_plus1, dump_idx;
  logic [31:0]      run_tmr;
  logic             accept, last_i, last_d, start_take;

  // The instruction port is write-only from this block.
  assign ren_ext = 1'b0;

  always_comb begin
    imem_clamp = (imem_count > CNT_W'(IMEM_WORDS)) ? CNT_W'(IMEM_WORDS) : imem_count;
    dmem_clamp = (dmem_count > CNT_W'(DMEM_WORDS)) ? CNT_W'(DMEM_WORDS) : dmem_count;
    dump_clamp = (dump_count > CNT_W'(DMEM_WORDS)) ? CNT_W'(DMEM_WORDS) : dump_count;
    accept     = s_valid && s_ready;
    idx_plus1  = word_cnt + CNT_W'(1);
    last_i     = (state_q == LOAD_I) && accept && (idx_plus1 == imem_q);
    last_d     = (state_q == LOAD_D) && accept && (idx_plus1 == dmem_q);
    start_take = start && !abort && ((state_q == IDLE) || (state_q == DONE));

    // run_tmr still holds the latched run_cycles until RUN is entered.
    start_first = (imem_clamp != '0) ? LOAD_I :
                  (dmem_clamp != '0) ? LOAD_D :
                  (run_cycles != 32'd0) ? RUN :
                  (dump_clamp != '0) ? DUMP_RD : DONE;
    after_i   = (dmem_q != '0) ? LOAD_D :
                (run_tmr != 32'd0) ? RUN :
                (dump_q != '0) ? DUMP_RD : DONE;
    after_d   = (run_tmr != 32'd0) ? RUN : (dump_q != '0) ? DUMP_RD : DONE;
    after_run = (dump_q != '0) ? DUMP_RD : DONE;

    // Word index of the next dump read; word_cnt is stale on entry from start
    // or a load phase, so those entries start from zero.
    dump_idx = (state_q == DUMP_OUT) ? idx_plus1 :
               (state_q == DUMP_RD)  ? word_cnt : '0;

    state_nxt = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_nxt = start_first;
      LOAD_I:     if (last_i) state_nxt = after_i;
      LOAD_D:     if (last_d) state_nxt = after_d;
      RUN:        if (run_tmr == 32'd0) state_nxt = after_run;
      DUMP_RD:    if (ren_ext_2) state_nxt = DUMP_CAP;
      DUMP_CAP:   state_nxt = DUMP_OUT;
      DUMP_OUT:   if (m_ready) state_nxt = (idx_plus1 == dump_q) ? DONE : DUMP_RD;
      default:    state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      imem_q      <= '0;
      dmem_q      <= '0;
      dump_q      <= '0;
      word_cnt    <= '0;
      run_tmr     <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      cpu_enable  <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      wen_ext    <= 1'b0;
      wen_ext_2  <= 1'b0;
      s_ready    <= (state_nxt == LOAD_I) || (state_nxt == LOAD_D);
      busy       <= (state_nxt != IDLE) && (state_nxt != DONE);
      done       <= (state_nxt == DONE);
      m_valid    <= (state_nxt == DUMP_OUT);
      cpu_enable <= (state_q == RUN) && (run_tmr != 32'd0) && !abort;
      // After LOAD_D the dmem port is still busy with the last write, so the
      // first read is issued one cycle later from DUMP_RD itself.
      ren_ext_2  <= (state_nxt == DUMP_RD) && (state_q != LOAD_D);

      if (start_take) begin
        imem_q   <= imem_clamp;
        dmem_q   <= dmem_clamp;
        dump_q   <= dump_clamp;
        run_tmr  <= run_cycles;
        word_cnt <= '0;
      end

      case (state_q)
        LOAD_I: if (accept && !abort) begin
          wen_ext   <= 1'b1;
          addr_ext  <= 64'({word_cnt, 2'b00});
          wdata_ext <= s_data[31:0];
          word_cnt  <= last_i ? '0 : idx_plus1;
        end
        LOAD_D: if (accept && !abort) begin
          wen_ext_2   <= 1'b1;
          addr_ext_2  <= 64'({word_cnt, 3'b000});
          wdata_ext_2 <= s_data;
          word_cnt    <= last_d ? '0 : idx_plus1;
        end
        RUN:      if (run_tmr != 32'd0) run_tmr <= run_tmr - 32'd1;
        DUMP_CAP: m_data <= rdata_ext_2;
        DUMP_OUT: if (m_ready && !abort) word_cnt <= idx_plus1;
        default: ;
      endcase

      if ((state_nxt == DUMP_RD) && (state_q != LOAD_D))
        addr_ext_2 <= 64'({dump_idx, 3'b000});
    end
  end

endmodule

// File: tb/tb_mem_boot_sequencer.sv
module tb_mem_boot_sequencer;

  logic        clk;
  logic        arst_n;
  logic        start, abort;
  logic [10:0] imem_count, dmem_count, dump_count;
  logic [31:0] run_cycles;
  logic        s_valid, s_ready;
  logic [63:0] s_data;
  logic        m_valid, m_ready;
  logic [63:0] m_data;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2, ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;

  mem_boot_sequencer dut (
    .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
    .imem_count(imem_count), .dmem_count(dmem_count),
    .run_cycles(run_cycles), .dump_count(dump_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External data memory with one-cycle read latency.
  logic [63:0] dmem [0:1023];
  initial rdata_ext_2 = '0;
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
  end

  // Passive logs of port activity, sampled mid-cycle.
  logic [63:0] iw_addr[$], iw_data[$], dw_addr[$], dw_data[$];
  int en_cycles = 0;
  int overlap   = 0;
  int ren_bad   = 0;
  always @(negedge clk) begin
    if (arst_n) begin
      if (wen_ext)   begin iw_addr.push_back(addr_ext);   iw_data.push_back(64'(wdata_ext)); end
      if (wen_ext_2) begin dw_addr.push_back(addr_ext_2); dw_data.push_back(wdata_ext_2); end
      if (cpu_enable) en_cycles++;
      if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2)) overlap++;
      if (ren_ext) ren_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int ic, input int dc, input int rc, input int pc);
    imem_count = 11'(ic);
    dmem_count = 11'(dc);
    run_cycles = 32'(rc);
    dump_count = 11'(pc);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("beat_timeout", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_mvalid(input string tag, input int budget);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin step(); n++; end
    chk(tag, 64'(m_valid), 64'd1);
  endtask

  function automatic logic any_out();
    return |{addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2,
             wdata_ext_2, m_valid, m_data, s_ready, cpu_enable, busy, done};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib, db, eb;
    arst_n = 1'b0; start = 1'b0; abort = 1'b0;
    imem_count = '0; dmem_count = '0; dump_count = '0; run_cycles = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #3;
    chk("reset_outputs", 64'(any_out()), 64'd0);
    @(negedge clk); arst_n = 1'b1;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Two-phase load, no run, no dump.
    ib = iw_addr.size(); db = dw_addr.size();
    do_start(3, 2, 0, 0);
    chk("t1_sready_after_start", 64'(s_ready), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    send_beat(64'h11); send_beat(64'h22); send_beat(64'h33);
    send_beat(64'hA);  send_beat(64'hB);
    chk("t1_last_wen2", 64'(wen_ext_2), 64'd1);
    chk("t1_last_addr2", addr_ext_2, 64'd8);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_sready_off", 64'(s_ready), 64'd0);
    step();
    chk("t1_iw_count", 64'(iw_addr.size() - ib), 64'd3);
    chk("t1_iw0", {iw_addr[ib],   iw_data[ib]  [31:0]}, {64'd0, 32'h11});
    chk("t1_iw1", {iw_addr[ib+1], iw_data[ib+1][31:0]}, {64'd4, 32'h22});
    chk("t1_iw2", {iw_addr[ib+2], iw_data[ib+2][31:0]}, {64'd8, 32'h33});
    chk("t1_dw_count", 64'(dw_addr.size() - db), 64'd2);
    chk("t1_dw0", {dw_addr[db],   dw_data[db]}, {64'd0, 64'hA});
    chk("t1_dw1", {dw_addr[db+1], dw_data[db+1]}, {64'd8, 64'hB});

    // Load with a gap in s_valid.
    ib = iw_addr.size();
    do_start(4, 0, 0, 0);
    send_beat(64'h101);
    step();
    send_beat(64'h102); send_beat(64'h103); send_beat(64'h104);
    step();
    chk("t2_iw_count", 64'(iw_addr.size() - ib), 64'd4);
    chk("t2_iw0", {iw_addr[ib],   iw_data[ib]  [31:0]}, {64'd0,  32'h101});
    chk("t2_iw1", {iw_addr[ib+1], iw_data[ib+1][31:0]}, {64'd4,  32'h102});
    chk("t2_iw2", {iw_addr[ib+2], iw_data[ib+2][31:0]}, {64'd8,  32'h103});
    chk("t2_iw3", {iw_addr[ib+3], iw_data[ib+3][31:0]}, {64'd12, 32'h104});
    chk("t2_done", 64'(done), 64'd1);

    // Run only.
    eb = en_cycles;
    do_start(0, 0, 5, 0);
    chk("t3_run_c1_enable", 64'(cpu_enable), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    step();
    chk("t3_run_c2_enable", 64'(cpu_enable), 64'd1);
    wait_done("t3_done", 20);
    step();
    chk("t3_enable_cycles", 64'(en_cycles - eb), 64'd5);
    chk("t3_enable_off", 64'(cpu_enable), 64'd0);

    // Load two data words then dump them with backpressure.
    do_start(0, 2, 0, 2);
    send_beat(64'hDEAD); send_beat(64'hBEEF);
    wait_mvalid("t4_mvalid0", 20);
    chk("t4_mdata0", m_data, 64'hDEAD);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_valid", 64'(m_valid), 64'd1);
      chk("t4_hold_data", m_data, 64'hDEAD);
    end
    m_ready = 1'b1;
    step();
    chk("t4_valid_drop", 64'(m_valid), 64'd0);
    wait_mvalid("t4_mvalid1", 20);
    chk("t4_mdata1", m_data, 64'hBEEF);
    step();
    m_ready = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_mvalid_off", 64'(m_valid), 64'd0);

    // Abort on the third RUN cycle, then rerun.
    do_start(1, 0, 10, 0);
    send_beat(64'h55);
    chk("t5_run_c1", 64'(cpu_enable), 64'd0);
    step();
    step();
    chk("t5_run_c3", 64'(cpu_enable), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_enable", 64'(cpu_enable), 64'd0);
    chk("t5_abort_busy", 64'(busy), 64'd0);
    chk("t5_abort_done", 64'(done), 64'd0);
    ib = iw_addr.size();
    do_start(1, 0, 0, 0);
    chk("t5_rerun_sready", 64'(s_ready), 64'd1);
    send_beat(64'h66);
    step();
    chk("t5_rerun_write", {64'(iw_addr.size() - ib), iw_addr[ib], iw_data[ib]},
        {64'd1, 64'd0, 64'h66});

    // Abort in the same cycle as an accepted beat drops the write.
    do_start(2, 0, 0, 0);
    ib = iw_addr.size();
    s_valid = 1'b1; s_data = 64'h77; abort = 1'b1;
    step();
    abort = 1'b0; s_valid = 1'b0;
    chk("t6_abort_wen", 64'(wen_ext), 64'd0);
    chk("t6_abort_sready", 64'(s_ready), 64'd0);
    step();
    chk("t6_no_write", 64'(iw_addr.size() - ib), 64'd0);

    // Oversized count clamps to the full instruction memory.
    ib = iw_addr.size();
    do_start(600, 0, 0, 0);
    s_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      s_data = 64'(i);
      step();
    end
    s_valid = 1'b0;
    chk("t7_last_wen", 64'(wen_ext), 64'd1);
    chk("t7_last_addr", addr_ext, 64'd2044);
    chk("t7_last_data", 64'(wdata_ext), 64'd511);
    chk("t7_sready_off", 64'(s_ready), 64'd0);
    chk("t7_done", 64'(done), 64'd1);
    step();
    chk("t7_write_count", 64'(iw_addr.size() - ib), 64'd512);

    // Asynchronous reset mid-load.
    do_start(10, 0, 0, 0);
    send_beat(64'h1); send_beat(64'h2); send_beat(64'h3);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t8_reset_outputs", 64'(any_out()), 64'd0);
    @(negedge clk); arst_n = 1'b1;
    step();

    chk("never_overlap", 64'(overlap), 64'd0);
    chk("ren_ext_never", 64'(ren_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_boot_sequencer.md
# mem_boot_sequencer

Top-level boot/run/dump controller for the pipelined RISC-V `cpu`. It streams a program image into instruction memory and data memory through the CPU's external memory ports while the core is held disabled. It then asserts the core `enable` for a programmed number of cycles and streams a data-memory region back out with backpressure. It sits between the testbench/host stream interface and the `cpu` top and owns every external-port signal of the `cpu`.

## Interface
- IMEM_WORDS, 512: instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024: data memory depth in 64-bit words.
- CNT_W, 11: width of the word-count inputs; must satisfy 2^CNT_W > DMEM_WORDS.
- clk  in  1  single clock for the whole design.
- arst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE on the next edge from any state.
- imem_count  in  CNT_W  instruction words to load.
- dmem_count  in  CNT_W  data words to load.
- run_cycles  in  32  cycles for which cpu enable is held high.
- dump_count  in  CNT_W  data words to read back, starting at data address 0.
- s_valid / s_ready / s_data  in / out / in  1/1/64  load stream; instruction beats use s_data[31:0].
- m_valid / m_ready / m_data  out / in / out  1/1/64  dump stream.
- cpu_enable  out  1  drives cpu `enable`.
- addr_ext, wen_ext, ren_ext, wdata_ext  out  64/1/1/32  instruction-memory external port.
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  64/1/1/64  data-memory external port.
- rdata_ext_2  in  64  data-memory external read data.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

## Operation
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
- Start handling:
  - On `start` in IDLE or DONE, latch all four counts and clear the word counter.
  - Each count is clamped to its memory depth: imem_count to IMEM_WORDS, dmem_count and dump_count to DMEM_WORDS.
  - The next state is the first state whose count is non-zero, in the order LOAD_I, LOAD_D, RUN, DUMP_RD. If all counts are zero, go to DONE.
- LOAD_I / LOAD_D:
  - s_ready = 1.
  - Each accepted beat (s_valid & s_ready) at index k produces a registered write on the following cycle. wen_ext (or wen_ext_2) is high for exactly one cycle, with addr = 4k (or 8k) as a byte address and the beat data.
  - When the last beat is accepted, move to the next non-zero phase. The counter resets on every phase change.
- RUN:
  - cpu_enable = 1 for exactly the latched run_cycles consecutive cycles, then 0.
  - Next state is DUMP_RD if dump_count is non-zero, else DONE.
- Dump loop, per word k:
  - DUMP_RD: ren_ext_2 = 1, addr_ext_2 = 8k.
  - DUMP_CAP: latch rdata_ext_2 (read latency is one cycle) into the m_data register.
  - DUMP_OUT: m_valid = 1. On m_ready, increment k. Go to DUMP_RD if words remain, else DONE.
- Stream rules:
  - m_data and m_valid are stable while m_valid & !m_ready.
  - s_ready = 0 outside the LOAD states. Beats offered there are not consumed.
- Port ownership: cpu_enable is never high in the same cycle as any wen_ext, wen_ext_2 or ren_ext_2. ren_ext = 0 always.
- DONE: holds done = 1 until `start` or `abort`.
- abort and reset behave identically:
  - State goes to IDLE; all strobes, cpu_enable, m_valid and s_ready go to 0.
  - A write already registered from a beat accepted in the abort cycle is dropped.

## Timing
- Reset values: all outputs 0. This covers every address bus, wdata, m_data, done and busy.
- start to first s_ready: 1 cycle.
- Load throughput: 1 beat/cycle. Write strobe lags the accepting beat by 1 cycle.
- Phase boundaries: the last LOAD_I write and the first LOAD_D acceptance may occur in the same cycle (different memories). The last write of the final load phase completes in the first RUN cycle, before cpu_enable rises. cpu_enable rises on cycle 2 of RUN, counted 1-based; RUN lasts run_cycles + 1 cycles.
- Dump: minimum 3 cycles per word. Each cycle of m_ready low adds one cycle.
- Simultaneous events:
  - abort wins over start and over any handshake.
  - start while busy is ignored.
  - A count of exactly IMEM_WORDS or DMEM_WORDS loads the full memory. Addresses never exceed (depth - 1) × word size.

## Test plan
- imem_count=3, dmem_count=2, run=0, dump=0, beats 0x11,0x22,0x33,0xA,0xB -> wen_ext pulses at addr 0,4,8; wen_ext_2 pulses at addr 0,8; done after the last write.
- s_valid toggled 1-0-1 during a 4-word imem load -> exactly 4 writes at addr 0,4,8,12 with no gaps in data order.
- run_cycles=5, other counts 0 -> cpu_enable high for exactly 5 cycles, never coincident with any memory strobe.
- dump_count=2 with memory words 0xDEAD, 0xBEEF and m_ready held low 3 cycles on the first word -> m_data stable at 0xDEAD while waiting, then 0xBEEF, then done=1.
- abort asserted on the 3rd RUN cycle -> cpu_enable=0 and busy=0 next cycle; a fresh start reruns from LOAD_I.
- imem_count=600 (> IMEM_WORDS) -> 512 writes, last addr 2044; arst_n pulsed mid-load -> all outputs 0 immediately.
